// File: rtl/rr_sched_32b_8b_pkg.sv
// Shared constants, types and byte-slicing helper for the 32b-to-8b
// round-robin byte-lane scheduler.
package rr_sched_32b_8b_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Byte k of a word, MSB first: k=0 is bits [31:24], k=3 is bits [7:0].
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input byte_idx_t k);
    logic [BYTE_W-1:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_sched_32b_8b_rr_arb.sv
// Combinational pointer-based round-robin arbiter: searches ptr+1, ptr+2, ...
// ptr (mod NUM_CH) and grants the first requester when enabled.
module rr_arb
  import rr_sched_32b_8b_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic            found;
  logic [CH_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = CH_W'((int'(ptr) + off) % NUM_CH);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sched_32b_8b.sv
// Round-robin scheduler sharing one byte lane between NUM_CH 32-bit word
// sources; words leave MSB byte first, tagged with channel and byte index.
module rr_sched_32b_8b
  import rr_sched_32b_8b_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*WORD_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [CH_W-1:0]          ch_out,
  output byte_idx_t                byte_idx,
  output logic                     last_out
);

  state_e            state_q, state_d;
  byte_idx_t         cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic              load;
  logic              arb_en;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [WORD_W-1:0] words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_words
    assign words[i] = req_data[i*WORD_W +: WORD_W];
  end

  assign load = (state_q == IDLE) || ((cnt_q == 2'd3) && out_ready);
  // No handshake is offered while held in reset, so req_ready reads 0 at once.
  assign arb_en = load && !reset;

  rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  // A load slot either captures the granted word or drops back to idle;
  // otherwise an accepted byte advances the index and a stall holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load) begin
      cnt_d = '0;
      if (|grant) begin
        state_d = SEND;
        word_d  = words[grant_idx];
        ch_d    = grant_idx;
        ptr_d   = grant_idx;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q == SEND) && out_ready) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_comb begin
    req_ready = grant;
    valid_out = 1'b0;
    data_out  = '0;
    ch_out    = '0;
    byte_idx  = '0;
    last_out  = 1'b0;
    if (state_q == SEND) begin
      valid_out = 1'b1;
      data_out  = word_byte(word_q, cnt_q);
      ch_out    = ch_q;
      byte_idx  = cnt_q;
      last_out  = (cnt_q == 2'd3);
    end
  end

endmodule

// File: tb/tb_rr_sched_32b_8b.sv
// Self-checking bench for rr_sched_32b_8b: a cycle model predicts grants and
// pushes expected bytes to a scoreboard that is popped as the lane emits them.
module tb_rr_sched_32b_8b;

  localparam int NUM_CH = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
    logic [1:0] idx;
    logic       last;
  } exp_byte_t;

  logic                 clk_4f = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*32-1:0] req_data;
  logic [NUM_CH-1:0]    req_ready;
  logic                 out_ready;
  logic [7:0]           data_out;
  logic                 valid_out;
  logic [1:0]           ch_out;
  logic [1:0]           byte_idx;
  logic                 last_out;

  exp_byte_t   sb[$];
  int          grant_log[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] ch_word [NUM_CH];
  int          pend    [NUM_CH];
  logic        m_busy;
  int          m_cnt;
  int          m_ptr;
  logic [NUM_CH-1:0] hs_q;

  rr_sched_32b_8b #(
    .NUM_CH (NUM_CH)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_ready (out_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ch_out    (ch_out),
    .byte_idx  (byte_idx),
    .last_out  (last_out)
  );

  always #5 clk_4f = ~clk_4f;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic pack_data();
    for (int i = 0; i < NUM_CH; i++) req_data[i*32 +: 32] = ch_word[i];
  endtask

  task automatic applyStimulus(input int ch, input logic [31:0] word, input int count);
    ch_word[ch]   = word;
    pend[ch]      = count;
    req_valid[ch] = (count > 0);
    pack_data();
  endtask

  // Runs at the falling edge: compares outputs with the model, then advances
  // the model to the state the coming rising edge will produce.
  task automatic monitor_step();
    logic              exp_load;
    logic [NUM_CH-1:0] exp_g;
    int                gi;
    exp_byte_t         e;
    logic [31:0]       w;
    if (reset) begin
      sb.delete();
      m_busy = 1'b0;
      m_cnt  = 0;
      m_ptr  = NUM_CH - 1;
      hs_q   = '0;
    end else begin
      exp_load = !m_busy || ((m_cnt == 3) && out_ready);
      exp_g    = '0;
      gi       = -1;
      if (exp_load) begin
        for (int off = 1; off <= NUM_CH; off++) begin
          int c;
          c = (m_ptr + off) % NUM_CH;
          if (gi < 0 && req_valid[c]) begin
            gi       = c;
            exp_g[c] = 1'b1;
          end
        end
      end
      checkOutput("req_ready", 32'(req_ready), 32'(exp_g));
      checkOutput("valid_out", 32'(valid_out), 32'(m_busy));
      if (m_busy) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb[0];
          checkOutput("data_out", 32'(data_out), 32'(e.data));
          checkOutput("ch_out",   32'(ch_out),   32'(e.ch));
          checkOutput("byte_idx", 32'(byte_idx), 32'(e.idx));
          checkOutput("last_out", 32'(last_out), 32'(e.last));
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        checkOutput("idle_data", 32'(data_out), 32'd0);
        checkOutput("idle_ch",   32'(ch_out),   32'd0);
        checkOutput("idle_idx",  32'(byte_idx), 32'd0);
        checkOutput("idle_last", 32'(last_out), 32'd0);
      end
      if (exp_load) begin
        m_cnt = 0;
        if (gi >= 0) begin
          m_busy = 1'b1;
          m_ptr  = gi;
          grant_log.push_back(gi);
          w = req_data[gi*32 +: 32];
          for (int k = 0; k < 4; k++) begin
            e.data = 8'(w >> (8 * (3 - k)));
            e.ch   = 2'(gi);
            e.idx  = 2'(k);
            e.last = (k == 3);
            sb.push_back(e);
          end
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_busy && out_ready) begin
        m_cnt++;
      end
      hs_q = req_valid & req_ready;
    end
  endtask

  task automatic tick();
    @(negedge clk_4f);
    monitor_step();
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hs_q[i] && pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_out), 32'd0);
    checkOutput({tag, "_data"},  32'(data_out),  32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_ch"},    32'(ch_out),    32'd0);
    checkOutput({tag, "_idx"},   32'(byte_idx),  32'd0);
    checkOutput({tag, "_last"},  32'(last_out),  32'd0);
  endtask

  initial begin
    int          g0;
    int          run;
    int          found;
    logic        seen;
    int          full_order[5];
    logic [7:0]  sw_bytes[4];

    full_order = '{0, 1, 2, 3, 0};
    sw_bytes   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    reset      = 1'b1;
    out_ready  = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    for (int i = 0; i < NUM_CH; i++) applyStimulus(i, 32'h5A5A0000 + 32'(i), 1);
    #2;
    check_all_zero("rst_init");
    repeat (2) tick();
    for (int i = 0; i < NUM_CH; i++) applyStimulus(i, 32'h0, 0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_valid", 32'(valid_out), 32'd0);

    $display("[TB] full load");
    g0 = grant_log.size();
    applyStimulus(0, 32'h11111111, 2);
    applyStimulus(1, 32'h22222222, 1);
    applyStimulus(2, 32'h33333333, 1);
    applyStimulus(3, 32'h44444444, 1);
    run  = 0;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (valid_out) begin
        run++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    checkOutput("full_run", 32'(run), 32'd20);
    checkOutput("full_grants", 32'(grant_log.size() - g0), 32'd5);
    for (int k = 0; k < 5; k++)
      if (g0 + k < grant_log.size())
        checkOutput("full_order", 32'(grant_log[g0+k]), 32'(full_order[k]));

    $display("[TB] single word");
    g0 = grant_log.size();
    applyStimulus(2, 32'hA1B2C3D4, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("single_data", 32'(data_out), 32'(sw_bytes[k]));
      checkOutput("single_ch",   32'(ch_out),   32'd2);
      checkOutput("single_idx",  32'(byte_idx), 32'(k));
      checkOutput("single_last", 32'(last_out), 32'(k == 3));
    end
    tick();
    checkOutput("single_end_valid", 32'(valid_out), 32'd0);
    checkOutput("single_end_data",  32'(data_out),  32'd0);
    checkOutput("single_grants", 32'(grant_log.size() - g0), 32'd1);

    $display("[TB] backpressure");
    applyStimulus(1, 32'hA1B2C3D4, 1);
    found = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (valid_out && byte_idx == 2'd1) begin
        found = 1;
        break;
      end
    end
    checkOutput("bp_reach", 32'(found), 32'd1);
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput("bp_hold_data",  32'(data_out),  32'hB2);
      checkOutput("bp_hold_idx",   32'(byte_idx),  32'd1);
      checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_resume_data", 32'(data_out), 32'hC3);
    checkOutput("bp_resume_idx",  32'(byte_idx), 32'd2);
    repeat (4) tick();

    $display("[TB] fairness");
    g0 = grant_log.size();
    applyStimulus(0, 32'h0F0F0F0F, 50);
    found = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (valid_out) begin
        found = 1;
        break;
      end
    end
    checkOutput("fair_start", 32'(found), 32'd1);
    applyStimulus(3, 32'h33CC33CC, 1);
    repeat (12) tick();
    checkOutput("fair_grants", 32'(grant_log.size() - g0 >= 3), 32'd1);
    if (grant_log.size() - g0 >= 3) begin
      checkOutput("fair_first",  32'(grant_log[g0]),   32'd0);
      checkOutput("fair_second", 32'(grant_log[g0+1]), 32'd3);
      checkOutput("fair_third",  32'(grant_log[g0+2]), 32'd0);
    end
    applyStimulus(0, 32'h0, 0);
    repeat (8) tick();

    $display("[TB] reset mid-word");
    applyStimulus(3, 32'hDEADBEEF, 20);
    applyStimulus(1, 32'hCAFEF00D, 20);
    found = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (valid_out && byte_idx == 2'd1) begin
        found = 1;
        break;
      end
    end
    checkOutput("midrst_reach", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    reset = 1'b0;
    checkOutput("midrst_release_valid", 32'(valid_out), 32'd0);
    g0 = grant_log.size();
    found = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (valid_out) begin
        found = 1;
        break;
      end
    end
    checkOutput("midrst_regrant", 32'(found), 32'd1);
    checkOutput("midrst_ch",  32'(ch_out),   32'd1);
    checkOutput("midrst_idx", 32'(byte_idx), 32'd0);
    if (grant_log.size() > g0) checkOutput("midrst_first_grant", 32'(grant_log[g0]), 32'd1);
    applyStimulus(1, 32'h0, 0);
    applyStimulus(3, 32'h0, 0);
    repeat (8) tick();

    $display("[TB] random traffic");
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend[c] == 0 && $urandom_range(0, 3) == 0)
          applyStimulus(c, $urandom, int'($urandom_range(1, 2)));
        else if (pend[c] > 0 && $urandom_range(0, 15) == 0)
          applyStimulus(c, ch_word[c], 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int c = 0; c < NUM_CH; c++) applyStimulus(c, 32'h0, 0);
    out_ready = 1'b1;
    repeat (12) tick();
    checkOutput("sb_drained",  32'(sb.size()),  32'd0);
    checkOutput("final_valid", 32'(valid_out),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_sched_32b_8b.md
Name: rr_sched_32b_8b

Overview:
Round-robin scheduler that shares one 32b-to-8b byte lane between NUM_CH 32-bit word sources.
- Each cycle a load is allowed, it grants one requesting channel and captures that channel's word.
- It emits the word MSB byte first, one byte per clk_4f cycle, tagged with the channel number and byte index.
- It sits between the per-lane word producers and the byte-wide link logic in the clk_4f domain.

Parameters:
NUM_CH, 4, number of requesting channels (2..8).
CH_W, $clog2(NUM_CH), width of the channel tag. Derived; do not override.

Ports:
clk_4f  in  1  byte-rate clock. Single clock, all state on its rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_CH  channel i has a word ready.
req_data  in  NUM_CH*32  channel i word in bits [32*i+31 : 32*i].
req_ready  out  NUM_CH  one-hot grant. A word transfers when req_valid[i] and req_ready[i] are both 1 at an edge.
out_ready  in  1  downstream accepts the current byte.
data_out  out  8  current byte.
valid_out  out  1  data_out is valid.
ch_out  out  CH_W  source channel of the current byte.
byte_idx  out  2  byte index: 0 = bits [31:24] … 3 = bits [7:0].
last_out  out  1  valid_out and byte_idx==3.

Behaviour:
- Reset (asynchronous): all outputs are 0 immediately.
  - busy=0, cnt=0, word_q=0, ch_q=0, ptr=NUM_CH-1 (channel 0 has first priority).
  - Any word in flight is dropped.
- State: busy (IDLE/SEND), cnt[1:0], word_q[31:0], ch_q, ptr.
- Outputs derive only from state registers:
  - valid_out=busy, data_out=word_q[31-8*cnt -: 8], ch_out=ch_q, byte_idx=cnt.
  - When busy=0: data_out=8'h00, ch_out=0, byte_idx=0.
- load = !busy OR (busy AND cnt==3 AND out_ready).
- Grant (combinational):
  - Only when load=1, pick the first i with req_valid[i] in order ptr+1, ptr+2, …, ptr (mod NUM_CH).
  - req_ready is one-hot for that i, else all 0.
  - req_ready never asserts when load=0.
- On a grant edge: word_q←req_data[i], ch_q←i, ptr←i, cnt←0, busy←1.
- On a load edge with no req_valid: busy←0 and cnt←0. word_q and ch_q may hold.
- Byte advance: busy AND out_ready AND cnt<3 → cnt←cnt+1.
- Stall: busy AND !out_ready → all state holds and data_out is stable.
- Latency:
  - Byte 0 is visible in the cycle after the grant edge.
  - With out_ready=1 and continuous requests there are no bubbles: 4 bytes per word, back-to-back words.
- Simultaneous events:
  - Byte 3 accepted and new requests in the same cycle: the next word is loaded on that same edge.
  - A req_valid deassert before grant withdraws the request; no state change.
- ptr moves only on a grant.
- req_data of non-granted channels is ignored.

Decomposition:
- Shared package holds:
  - BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4.
  - byte_idx type (2 bits).
  - Function slicing byte k of a word, MSB first.
- One sub-module, rr_arb: combinational pointer-based round-robin. Inputs req[NUM_CH], ptr, en. Outputs one-hot grant and encoded index.

Test Plan:
1. Reset check:
   - Stimulus: assert reset mid-stream.
   - Response: valid_out, data_out, req_ready, ch_out, byte_idx and last_out are all 0 before the next clk_4f edge.
2. Single word:
   - Stimulus: ch2 valid with 32'hA1B2C3D4, out_ready=1.
   - Response: req_ready=4'b0100 for exactly 1 cycle.
   - Next 4 cycles: data_out A1,B2,C3,D4 with ch_out=2, byte_idx 0..3, last_out on D4.
   - Then valid_out=0 and data_out=00.
3. Full load:
   - Stimulus: all 4 channels valid, ch i word = 32'h11111111*(i+1).
   - Response: grants in order 0,1,2,3,0; valid_out stays high 20 cycles with no gap.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles while B2 is shown.
   - Response: data_out holds B2, byte_idx holds 1, req_ready stays 0.
   - C3 appears 1 cycle after out_ready returns.
5. Fairness:
   - Stimulus: ch0 valid continuously; ch3 raises once while ch0's word is being sent.
   - Response: ch3 is granted at the next word boundary, then ch0 again.
6. Reset mid-word:
   - Stimulus: reset after byte_idx=1 is shown.
   - Response: no residual bytes after release. First grant goes to the lowest valid channel from ch0.
